// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - per-register latency scoreboard with stall/flush control
module scoreboard_hazard_unit #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = $clog2(NUM_REGS),
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  reg_we_id,
  input  logic [CNT_W-1:0]      latency_id,
  input  logic                  multicycle_id,
  input  logic                  mc_done,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic                  branch_taken,
  input  logic                  interrupt,
  input  logic                  flush_all,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  stall_wb,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic                  flush_wb,
  output logic                  mc_busy,
  output logic [PERF_W-1:0]     stall_count
);

  // Remaining bubbles before each register's fixed-latency result is usable.
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  // Register awaits a result from the iterative unit.
  logic [NUM_REGS-1:0] mc_pend;

  logic raw_1;
  logic raw_2;
  logic waw;
  logic struct_hz;
  logic hz;
  logic issue;
  logic issue_fixed_wr;
  logic issue_mc_wr;

  // Hazard detection from registered scoreboard state; mc_done releases only the structural term.
  always_comb begin
    raw_1     = rs1_used_id && (rs1_id != '0) && ((cnt[rs1_id] != '0) || mc_pend[rs1_id]);
    raw_2     = rs2_used_id && (rs2_id != '0) && ((cnt[rs2_id] != '0) || mc_pend[rs2_id]);
    waw       = reg_we_id && (rd_id != '0) && mc_pend[rd_id];
    struct_hz = multicycle_id && mc_busy && !mc_done;
    hz        = issue_valid_id && (raw_1 || raw_2 || waw || struct_hz);
  end

  // Per-stage stall/flush lines; a full flush overrides the ID stall.
  always_comb begin
    stall_if       = hz && !flush_all;
    stall_id       = hz && !flush_all;
    stall_ex       = interrupt;
    stall_mem      = interrupt;
    stall_wb       = interrupt;
    flush_id       = branch_taken || interrupt || flush_all;
    flush_ex       = (hz && !flush_all) || flush_all;
    flush_mem      = flush_all;
    flush_wb       = flush_all;
    issue          = issue_valid_id && !stall_id && !flush_id;
    issue_fixed_wr = issue && reg_we_id && (rd_id != '0) && !multicycle_id;
    issue_mc_wr    = issue && reg_we_id && (rd_id != '0) && multicycle_id;
  end

  // Scoreboard update: issue writes beat decrement, mc set beats mc_done clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      mc_pend <= '0;
      mc_busy <= 1'b0;
    end else if (flush_all) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      mc_pend <= '0;
      mc_busy <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue_fixed_wr && (rd_id == REG_ADDR_W'(r))) begin
          cnt[r] <= latency_id;
        end else if (!interrupt && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
        if (issue_mc_wr && (rd_id == REG_ADDR_W'(r))) begin
          mc_pend[r] <= 1'b1;
        end else if (mc_done && (mc_rd != '0) && (mc_rd == REG_ADDR_W'(r))) begin
          mc_pend[r] <= 1'b0;
        end
      end
      if (issue && multicycle_id) begin
        mc_busy <= 1'b1;
      end else if (mc_done) begin
        mc_busy <= 1'b0;
      end
    end
  end

  // Saturating count of ID stall cycles; survives flush_all.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_id && (stall_count != '1)) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - scenario-driven scoreboard bench for scoreboard_hazard_unit
module tb_scoreboard_hazard_unit;

  typedef struct {
    logic       v, u;
    logic [4:0] rs1, rs2, rd;
    logic       we;
    logic [3:0] lat;
    logic       mc, done;
    logic [4:0] mcrd;
    logic       br, irq, fa, hz, busy;
  } row_t;

  typedef struct {
    logic [9:0]  vec;
    logic [31:0] sc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid_id, rs1_used_id, rs2_used_id, reg_we_id, multicycle_id;
  logic [4:0]  rs1_id, rs2_id, rd_id, mc_rd;
  logic [3:0]  latency_id;
  logic        mc_done, branch_taken, interrupt, flush_all;
  logic        stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic        flush_id, flush_ex, flush_mem, flush_wb, mc_busy;
  logic [31:0] stall_count;
  logic        s_stall_if, s_stall_id, s_stall_ex, s_stall_mem, s_stall_wb;
  logic        s_flush_id, s_flush_ex, s_flush_mem, s_flush_wb, s_mc_busy;
  logic [2:0]  sat_count;

  int    checks = 0;
  int    failures = 0;
  int    exp_sc = 0;
  exp_t  exp_q[$];

  wire [9:0] outs_vec = {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                         flush_id, flush_ex, flush_mem, flush_wb, mc_busy};

  always #5 clock = ~clock;

  scoreboard_hazard_unit dut (
    .clock(clock), .reset(reset), .issue_valid_id(issue_valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_we_id(reg_we_id), .latency_id(latency_id), .multicycle_id(multicycle_id),
    .mc_done(mc_done), .mc_rd(mc_rd), .branch_taken(branch_taken), .interrupt(interrupt),
    .flush_all(flush_all), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush_id(flush_id), .flush_ex(flush_ex),
    .flush_mem(flush_mem), .flush_wb(flush_wb), .mc_busy(mc_busy), .stall_count(stall_count)
  );

  scoreboard_hazard_unit #(.PERF_W(3)) dut_sat (
    .clock(clock), .reset(reset), .issue_valid_id(issue_valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_we_id(reg_we_id), .latency_id(latency_id), .multicycle_id(multicycle_id),
    .mc_done(mc_done), .mc_rd(mc_rd), .branch_taken(branch_taken), .interrupt(interrupt),
    .flush_all(flush_all), .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex),
    .stall_mem(s_stall_mem), .stall_wb(s_stall_wb), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
    .flush_mem(s_flush_mem), .flush_wb(s_flush_wb), .mc_busy(s_mc_busy), .stall_count(sat_count)
  );

  function automatic row_t mk(int v, int u, int rs1, int rs2, int rd, int we, int lat,
                              int mc, int done, int mcrd, int br, int irq, int fa,
                              int hz, int busy);
    row_t r;
    r.v = (v != 0);     r.u = (u != 0);
    r.rs1 = 5'(rs1);    r.rs2 = 5'(rs2);   r.rd = 5'(rd);
    r.we = (we != 0);   r.lat = 4'(lat);
    r.mc = (mc != 0);   r.done = (done != 0); r.mcrd = 5'(mcrd);
    r.br = (br != 0);   r.irq = (irq != 0);   r.fa = (fa != 0);
    r.hz = (hz != 0);   r.busy = (busy != 0);
    return r;
  endfunction

  // Apply one cycle of ID inputs and push the outputs the spec requires for it.
  task automatic drive(input row_t r);
    exp_t e;
    logic st;
    issue_valid_id = r.v;  rs1_used_id = r.u;  rs2_used_id = r.u;
    rs1_id = r.rs1;  rs2_id = r.rs2;  rd_id = r.rd;  reg_we_id = r.we;
    latency_id = r.lat;  multicycle_id = r.mc;  mc_done = r.done;  mc_rd = r.mcrd;
    branch_taken = r.br;  interrupt = r.irq;  flush_all = r.fa;
    st = r.hz && !r.fa;
    e.vec = {st, st, r.irq, r.irq, r.irq, r.br || r.irq || r.fa, st || r.fa, r.fa, r.fa, r.busy};
    e.sc = 32'(exp_sc);
    exp_q.push_back(e);
    if (st) exp_sc++;
  endtask

  task automatic test_reset;
    row_t rows[$];
    exp_t e;
    rows = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), mk(1,1,1,2,3,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL reset[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL reset[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_load_use;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,5,1,1,0,0,0,0,0,0,0,0),
             mk(1,1,5,0,0,0,0,0,0,0,0,0,0,1,0),
             mk(1,1,5,0,0,0,0,0,0,0,0,0,0,0,0),
             mk(1,0,0,0,6,1,2,0,0,0,0,0,0,0,0),
             mk(1,0,6,6,0,0,0,0,0,0,0,0,0,0,0),
             mk(1,1,0,6,0,0,0,0,0,0,0,0,0,1,0),
             mk(1,1,0,6,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL load_use[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL load_use[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_interrupt_freeze;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,7,1,3,0,0,0,0,0,0,0,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,0,0,1,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,1,0,1,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,1,0,1,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,0,0,1,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,0,0,1,0),
             mk(1,1,7,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL irq_freeze[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL irq_freeze[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_multicycle_struct;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,9,1,0,1,0,0,0,0,0,0,0),
             mk(1,0,0,0,10,1,0,1,0,0,0,0,0,1,1),
             mk(1,0,0,0,10,1,0,1,0,0,0,0,0,1,1),
             mk(1,0,0,0,10,1,0,1,1,9,0,0,0,0,1),
             mk(1,1,9,0,0,0,0,0,0,0,0,0,0,0,1),
             mk(1,1,10,0,0,0,0,0,0,0,0,0,0,1,1),
             mk(1,1,10,0,0,0,0,0,1,10,0,0,0,1,1),
             mk(1,1,10,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL mc_struct[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL mc_struct[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_waw;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,3,1,0,1,0,0,0,0,0,0,0),
             mk(1,0,0,0,3,1,0,0,0,0,0,0,0,1,1),
             mk(1,0,0,0,3,1,0,0,1,3,0,0,0,1,1),
             mk(1,0,0,0,3,1,0,0,0,0,0,0,0,0,0),
             mk(1,0,0,0,3,1,0,1,0,0,0,0,0,0,0),
             mk(1,1,3,0,0,0,0,0,0,0,0,0,0,1,1),
             mk(1,1,3,0,0,0,0,0,1,3,0,0,0,1,1),
             mk(1,1,3,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL waw[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL waw[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_x0;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,0,1,5,0,0,0,0,0,0,0,0),
             mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0),
             mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL x0[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL x0[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_flush_all;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,4,1,3,0,0,0,0,0,0,0,0),
             mk(1,0,0,0,11,1,0,1,0,0,0,0,0,0,0),
             mk(1,1,4,0,0,0,0,0,0,0,0,0,1,1,1),
             mk(1,1,4,0,0,0,0,0,0,0,0,0,0,0,0),
             mk(1,1,11,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL flush_all[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL flush_all[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_branch;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,12,1,1,0,0,0,0,0,0,0,0),
             mk(1,1,12,0,0,0,0,0,0,0,1,0,0,1,0),
             mk(1,0,0,0,13,1,2,0,0,0,1,0,0,0,0),
             mk(1,1,13,0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL branch[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
      checks++;
      if (stall_count !== e.sc) begin failures++; $display("FAIL branch[%0d] stall_count got=%0d exp=%0d", i, stall_count, e.sc); end
    end
  endtask

  task automatic test_saturation;
    exp_t e;
    logic [2:0] want;
    @(negedge clock); drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)); #1;
    e = exp_q.pop_front();
    want = (e.sc > 32'd7) ? 3'd7 : e.sc[2:0];
    checks++;
    if (stall_count !== e.sc) begin failures++; $display("FAIL sat wide stall_count got=%0d exp=%0d", stall_count, e.sc); end
    checks++;
    if (sat_count !== want) begin failures++; $display("FAIL sat narrow stall_count got=%0d exp=%0d", sat_count, want); end
  endtask

  task automatic test_async_reset;
    row_t rows[$];
    exp_t e;
    rows = '{mk(1,0,0,0,5,1,3,0,0,0,0,0,0,0,0),
             mk(1,1,5,0,0,0,0,0,0,0,0,0,0,1,0)};
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock); drive(rows[i]); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs_vec !== e.vec) begin failures++; $display("FAIL async_rst[%0d] outs got=%b exp=%b", i, outs_vec, e.vec); end
    end
    #1 reset = 1'b0;
    exp_sc = 0;
    #1 drive(mk(1,1,5,0,0,0,0,0,0,0,0,0,0,0,0)); #1;
    e = exp_q.pop_front();
    checks++;
    if (outs_vec !== e.vec) begin failures++; $display("FAIL async_rst mid outs got=%b exp=%b", outs_vec, e.vec); end
    checks++;
    if (stall_count !== e.sc) begin failures++; $display("FAIL async_rst mid stall_count got=%0d exp=%0d", stall_count, e.sc); end
    @(negedge clock); reset = 1'b1;
    drive(mk(1,1,5,0,0,0,0,0,0,0,0,0,0,0,0)); #1;
    e = exp_q.pop_front();
    checks++;
    if (outs_vec !== e.vec) begin failures++; $display("FAIL async_rst post outs got=%b exp=%b", outs_vec, e.vec); end
  endtask

  initial begin
    issue_valid_id = 0; rs1_used_id = 0; rs2_used_id = 0; reg_we_id = 0; multicycle_id = 0;
    rs1_id = 0; rs2_id = 0; rd_id = 0; mc_rd = 0; latency_id = 0;
    mc_done = 0; branch_taken = 0; interrupt = 0; flush_all = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    test_reset;
    test_load_use;
    test_interrupt_freeze;
    test_multicycle_struct;
    test_waw;
    test_x0;
    test_flush_all;
    test_branch;
    test_saturation;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised scoreboard hazard unit for the 5-stage core.
- Replaces the fixed load-use comparison with per-register remaining-latency counters, so any result latency is handled: ALU 0, load 1, CSR/FPU N.
- Tracks one shared iterative unit (mul/div), raising structural and WAW stalls for it.
- Drives the per-stage stall/flush lines and a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- REG_ADDR_W, $clog2(NUM_REGS), width of register indices.
- CNT_W, 4, width of the per-register latency counter; maximum latency is 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- issue_valid_id  in  1  valid instruction in ID, which issues to EX when stall_id=0 and flush_id=0.
- rs1_id / rs2_id  in  REG_ADDR_W each  source indices in ID.
- rs1_used_id / rs2_used_id  in  1 each  source actually read.
- rd_id  in  REG_ADDR_W  destination in ID.
- reg_we_id  in  1  instruction writes rd.
- latency_id  in  CNT_W  bubbles a dependent instruction needs (fixed-latency ops).
- multicycle_id  in  1  instruction uses the iterative unit.
- mc_done  in  1  iterative unit completes this cycle.
- mc_rd  in  REG_ADDR_W  destination of the completing op.
- branch_taken  in  1  PC source is not PC+4.
- interrupt  in  1  trap entry.
- flush_all  in  1  full pipeline flush.
- stall_if, stall_id, stall_ex, stall_mem, stall_wb  out  1 each.
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each.
- mc_busy  out  1  iterative unit occupied.
- stall_count  out  PERF_W  cycles with stall_id=1, saturating.

Behaviour:
State:
- cnt[r] (CNT_W bits) per register.
- mc_pend[r] (1 bit) per register.
- mc_busy.
- stall_count.
- Reset (reset=0, async): all state cleared to 0.
- Outputs after reset with inputs idle: all stalls/flushes 0, mc_busy=0, stall_count=0.

Hazard terms (combinational from registered state plus ID inputs; x is 1 or 2):
- raw_x = rsx_used_id && rsx_id != 0 && (cnt[rsx_id] != 0 || mc_pend[rsx_id]).
- waw = reg_we_id && rd_id != 0 && mc_pend[rd_id].
- struct = multicycle_id && mc_busy && !mc_done.
- hz = issue_valid_id && (raw_1 || raw_2 || waw || struct).
- raw is NOT released by a same-cycle mc_done for that register (registered release); struct IS released by a same-cycle mc_done.

Outputs:
- stall_if = stall_id = hz && !flush_all.
- flush_id = branch_taken || interrupt || flush_all.
- flush_ex = (hz && !flush_all) || flush_all.
- flush_mem = flush_wb = flush_all.
- stall_ex = stall_mem = stall_wb = interrupt.
- branch_taken with hz: both flush_id and stall_id assert; the ID flush wins in the pipeline register.

Issue event:
- issue = issue_valid_id && !stall_id && !flush_id.
- On issue && reg_we_id && rd_id != 0:
  - if multicycle_id: mc_pend[rd_id] <= 1;
  - else: cnt[rd_id] <= latency_id.
- On issue && multicycle_id: mc_busy <= 1.

Counters:
- Each cycle with interrupt=0, every nonzero cnt[r] not being written by the issue event decrements by 1.
- When interrupt=1, cnt is frozen.
- Issue write beats decrement for the same register.
- Latency L therefore gives exactly L stall cycles to an immediately-following dependent instruction; L=0 never stalls.

Multicycle:
- mc_done clears mc_pend[mc_rd] (if mc_rd != 0) and mc_busy.
- If a new multicycle op issues the same cycle, mc_busy stays 1 and mc_pend is set for the new rd.
- Set-over-clear applies when the new rd equals mc_rd.

flush_all:
- Next edge: all cnt <= 0, mc_pend <= 0, mc_busy <= 0 (the iterative unit is aborted externally).
- No issue is recorded that cycle.
- stall_count is not cleared.

stall_count:
- Increments when stall_id=1.
- Holds at 2^PERF_W-1.

Test Plan:
- Load x5 (latency_id=1) issued, next instruction reads rs1=x5 → stall_if/stall_id/flush_ex=1 for exactly 1 cycle, then issues; stall_count=1.
- Op with latency_id=3 on x7, dependent follows; interrupt pulsed 2 cycles mid-wait → stall lasts 3+2=5 cycles, stall_ex/mem/wb=1 only during the interrupt.
- Multicycle div to x9 issued; second div (rd=x10) arrives while mc_busy → struct stall until mc_done.
  - Same-cycle mc_done → second issues that cycle; mc_busy stays 1, mc_pend[x10]=1, mc_pend[x9]=0.
- Pending div to x3; ALU op writing x3 → waw stall. Reader of x3 stalls through the mc_done cycle and issues the following cycle.
- Instruction using rs=x0 after "write" to x0 with latency_id=5 → no stall, no state written.
- cnt[x4]=2 and mc_busy=1, then flush_all → flush_id/ex/mem/wb=1, stall_id=0. Next cycle cnt[x4]=0, mc_busy=0, and a reader of x4 issues immediately.
- Async reset asserted mid-stall → all outputs 0 immediately.
